multicycle_control_fsm: RTL and testbench

//   Main control unit of the multicycle MIPS datapath; producer side of the ALUOp[2:0] bus consumed by ALUControl.

---
 rtl/multicycle_control_fsm.sv | 179 +++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Main control unit of the multicycle MIPS datapath: a Moore FSM that drives the
// datapath enables, mux selects and ALUOp, stalls on MemReady and counts retired instructions.
module multicycle_control_fsm #(
    parameter int TRAP_ON_ILLEGAL = 1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             BranchNE,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic [2:0]       ALUOp,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);
    // state    | meaning
    // RST      | after reset, all outputs low      FETCH  | read instr at PC, PC+4
    // DECODE   | latch opcode, branch target       MEM_*  | LW/SW address, read, writeback, write
    // R_*/I_*  | ALU op and register writeback     BRANCH | conditional PC load
    // JUMP     | PC <= jump target                 TRAP   | illegal opcode, wait for reset
    typedef enum logic [3:0] {
        S_RST, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    typedef struct packed {
        logic       pcw, pcwc, bne, iord, mrd, mwr, m2r, rdst, rw, srca;
        logic [1:0] srcb, pcsrc;
        logic [2:0] aluop;
        logic       ill;
    } ctl_t;

    state_t           r_state, w_next;
    logic [5:0]       r_op, w_op_next;
    ctl_t             r_ctl, w_ctl_next;
    logic [CNT_W-1:0] r_retired;
    logic             w_retire, w_ill_pulse;

    function automatic logic [2:0] imm_aluop(input logic [5:0] op);
        case (op)
            OP_ORI:  return 3'b101;
            OP_ANDI: return 3'b110;
            OP_LUI:  return 3'b001;
            default: return 3'b100;
        endcase
    endfunction

    function automatic ctl_t ctl_of(input state_t s, input logic [5:0] op);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.mrd = 1'b1; c.srcb = 2'b01; c.aluop = 3'b100; end
            S_DECODE:   begin c.srcb = 2'b11; c.aluop = 3'b100; end
            S_MEM_ADDR: begin c.srca = 1'b1; c.srcb = 2'b10; c.aluop = 3'b010; end
            S_MEM_RD:   begin c.mrd = 1'b1; c.iord = 1'b1; end
            S_MEM_WB:   begin c.m2r = 1'b1; c.rw = 1'b1; end
            S_MEM_WR:   begin c.mwr = 1'b1; c.iord = 1'b1; end
            S_R_EXEC:   begin c.srca = 1'b1; c.aluop = 3'b111; end
            S_R_WB:     begin c.aluop = 3'b111; c.rdst = 1'b1; c.rw = 1'b1; end
            S_I_EXEC:   begin c.srca = 1'b1; c.srcb = 2'b10; c.aluop = imm_aluop(op); end
            S_I_WB:     begin c.aluop = imm_aluop(op); c.rw = 1'b1; end
            S_BRANCH:   begin
                c.srca  = 1'b1;
                c.aluop = 3'b011;
                c.pcwc  = 1'b1;
                c.pcsrc = 2'b01;
                c.bne   = (op == OP_BNE);
            end
            S_JUMP:     begin c.pcw = 1'b1; c.pcsrc = 2'b10; end
            S_TRAP:     c.ill = 1'b1;
            default:    c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        w_next      = S_FETCH;
        w_op_next   = r_op;
        w_retire    = 1'b0;
        w_ill_pulse = 1'b0;
        case (r_state)
            S_RST:      w_next = S_FETCH;
            S_FETCH:    w_next = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                w_op_next = Opcode;
                case (Opcode)
                    OP_LW, OP_SW:                      w_next = S_MEM_ADDR;
                    OP_R:                              w_next = S_R_EXEC;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:  w_next = S_I_EXEC;
                    OP_BEQ, OP_BNE:                    w_next = S_BRANCH;
                    OP_J:                              w_next = S_JUMP;
                    default: begin
                        if (TRAP_ON_ILLEGAL != 0) begin
                            w_next = S_TRAP;
                        end else begin
                            w_next      = S_FETCH;
                            w_ill_pulse = 1'b1;
                        end
                    end
                endcase
            end
            S_MEM_ADDR: w_next = (r_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   w_next = MemReady ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR: begin
                w_next   = MemReady ? S_FETCH : S_MEM_WR;
                w_retire = MemReady;
            end
            S_R_EXEC:   w_next = S_R_WB;
            S_I_EXEC:   w_next = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_FETCH;
        endcase
        w_ctl_next     = ctl_of(w_next, w_op_next);
        w_ctl_next.ill = w_ctl_next.ill | w_ill_pulse;
    end

    // Outputs are registered from the next state, so they change exactly with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_RST;
            r_op      <= '0;
            r_ctl     <= '0;
            r_retired <= '0;
        end else begin
            r_state   <= w_next;
            r_op      <= w_op_next;
            r_ctl     <= w_ctl_next;
            r_retired <= r_retired + {{(CNT_W-1){1'b0}}, w_retire};
        end
    end

    // The fetch-time IR/PC loads follow MemReady within the cycle.
    assign IRWrite     = (r_state == S_FETCH) & MemReady;
    assign PCWrite     = r_ctl.pcw | IRWrite;
    assign PCWriteCond = r_ctl.pcwc;
    assign BranchNE    = r_ctl.bne;
    assign IorD        = r_ctl.iord;
    assign MemRead     = r_ctl.mrd;
    assign MemWrite    = r_ctl.mwr;
    assign MemtoReg    = r_ctl.m2r;
    assign RegDst      = r_ctl.rdst;
    assign RegWrite    = r_ctl.rw;
    assign ALUSrcA     = r_ctl.srca;
    assign ALUSrcB     = r_ctl.srcb;
    assign PCSource    = r_ctl.pcsrc;
    assign ALUOp       = r_ctl.aluop;
    assign illegal_op  = r_ctl.ill;
    assign retired     = r_retired;
    assign state       = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboarded random test of multicycle_control_fsm: a per-instruction reference model
// queues the expected control vector for every cycle; a monitor compares at negedge.
module tb_multicycle_control_fsm;

    typedef struct packed {
        logic       pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, pcsrc;
        logic [2:0] aluop;
        logic       ill;
    } ctl_t;

    typedef struct {
        bit          sel;
        ctl_t        c;
        int unsigned ret;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1, rst_b = 1'b1;
    logic       mem_ready = 1'b0;
    logic [5:0] opcode = '0;

    always #5 clk = ~clk;

    logic a_pcw, a_pcwc, a_bne, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rdst, a_rw, a_srca, a_ill;
    logic b_pcw, b_pcwc, b_bne, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rdst, b_rw, b_srca, b_ill;
    logic [1:0]  a_srcb, a_pcsrc, b_srcb, b_pcsrc;
    logic [2:0]  a_aluop, b_aluop;
    logic [3:0]  a_ret, a_state, b_state;
    logic [31:0] b_ret;
    ctl_t        a_ctl, b_ctl;

    assign a_ctl = {a_pcw, a_pcwc, a_bne, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rdst, a_rw,
                    a_srca, a_srcb, a_pcsrc, a_aluop, a_ill};
    assign b_ctl = {b_pcw, b_pcwc, b_bne, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rdst, b_rw,
                    b_srca, b_srcb, b_pcsrc, b_aluop, b_ill};

    // DUT A: illegal opcodes pulse and continue, 4-bit counter; DUT B: trapping, 32-bit counter.
    multicycle_control_fsm #(.TRAP_ON_ILLEGAL(0), .CNT_W(4)) dut_a (
        .clk(clk), .reset(rst_a), .Opcode(opcode), .MemReady(mem_ready),
        .PCWrite(a_pcw), .PCWriteCond(a_pcwc), .BranchNE(a_bne), .IorD(a_iord),
        .MemRead(a_mrd), .MemWrite(a_mwr), .IRWrite(a_irw), .MemtoReg(a_m2r),
        .RegDst(a_rdst), .RegWrite(a_rw), .ALUSrcA(a_srca), .ALUSrcB(a_srcb),
        .PCSource(a_pcsrc), .ALUOp(a_aluop), .illegal_op(a_ill), .retired(a_ret),
        .state(a_state)
    );

    multicycle_control_fsm #(.TRAP_ON_ILLEGAL(1), .CNT_W(32)) dut_b (
        .clk(clk), .reset(rst_b), .Opcode(opcode), .MemReady(mem_ready),
        .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .BranchNE(b_bne), .IorD(b_iord),
        .MemRead(b_mrd), .MemWrite(b_mwr), .IRWrite(b_irw), .MemtoReg(b_m2r),
        .RegDst(b_rdst), .RegWrite(b_rw), .ALUSrcA(b_srca), .ALUSrcB(b_srcb),
        .PCSource(b_pcsrc), .ALUOp(b_aluop), .illegal_op(b_ill), .retired(b_ret),
        .state(b_state)
    );

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    bit          sel = 1'b0;
    bit          pend = 1'b0;
    int unsigned ret = 0;
    logic [3:0]  rst_enc_a, rst_enc_b;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.sel) begin
                    chk("ctl_b", 32'(b_ctl), 32'(e.c));
                    chk("retired_b", b_ret, e.ret);
                end else begin
                    chk("ctl_a", 32'(a_ctl), 32'(e.c));
                    chk("retired_a", {28'b0, a_ret}, e.ret % 16);
                end
            end
        end
    end

    function automatic bit is_legal(input logic [5:0] op);
        case (op)
            6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic ctl_t v_fetch(input bit rdy, input bit ill);
        ctl_t c;
        c = '0;
        c.mrd = 1'b1; c.srcb = 2'b01; c.aluop = 3'b100;
        c.irw = rdy;  c.pcw = rdy;    c.ill = ill;
        return c;
    endfunction

    function automatic bit rbit();
        return bit'($urandom_range(0, 1));
    endfunction

    task automatic cyc(input bit mr, input logic [5:0] op, input ctl_t c);
        exp_t e;
        @(posedge clk);
        #1;
        mem_ready = mr;
        opcode    = op;
        e.sel = sel; e.c = c; e.ret = ret;
        q.push_back(e);
    endtask

    task automatic rst_seq();
        exp_t e;
        ret  = 0;
        pend = 1'b0;
        e.sel = sel; e.c = '0; e.ret = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (sel) rst_b = 1'b1; else rst_a = 1'b1;
            mem_ready = rbit();
            q.push_back(e);
            if (i == 0) begin
                @(negedge clk);
                #1;
                if (sel) rst_enc_b = b_state; else rst_enc_a = a_state;
            end
        end
        @(posedge clk);
        #1;
        if (sel) rst_b = 1'b0; else rst_a = 1'b0;
        q.push_back(e);
    endtask

    // Reference model: the cycle-by-cycle control sequence of one instruction.
    task automatic run_instr(input logic [5:0] op, input int fs, input int ms);
        ctl_t c;
        logic [2:0] iop;
        for (int i = 0; i < fs; i++) begin
            cyc(1'b0, 6'($urandom), v_fetch(1'b0, pend));
            pend = 1'b0;
        end
        cyc(1'b1, 6'($urandom), v_fetch(1'b1, pend));
        pend = 1'b0;
        c = '0; c.srcb = 2'b11; c.aluop = 3'b100;
        cyc(rbit(), op, c);
        if (op == 6'h23 || op == 6'h2B) begin
            c = '0; c.srca = 1'b1; c.srcb = 2'b10; c.aluop = 3'b010;
            cyc(rbit(), op, c);
            c = '0; c.iord = 1'b1;
            if (op == 6'h23) c.mrd = 1'b1; else c.mwr = 1'b1;
            for (int i = 0; i < ms; i++) cyc(1'b0, op, c);
            cyc(1'b1, op, c);
            if (op == 6'h23) begin
                c = '0; c.m2r = 1'b1; c.rw = 1'b1;
                cyc(rbit(), op, c);
            end
        end else if (op == 6'h00) begin
            c = '0; c.srca = 1'b1; c.aluop = 3'b111;
            cyc(rbit(), op, c);
            c = '0; c.aluop = 3'b111; c.rdst = 1'b1; c.rw = 1'b1;
            cyc(rbit(), op, c);
        end else if (op == 6'h08 || op == 6'h0C || op == 6'h0D || op == 6'h0F) begin
            iop = (op == 6'h08) ? 3'b100 : (op == 6'h0D) ? 3'b101 :
                  (op == 6'h0C) ? 3'b110 : 3'b001;
            c = '0; c.srca = 1'b1; c.srcb = 2'b10; c.aluop = iop;
            cyc(rbit(), op, c);
            c = '0; c.aluop = iop; c.rw = 1'b1;
            cyc(rbit(), op, c);
        end else if (op == 6'h04 || op == 6'h05) begin
            c = '0; c.srca = 1'b1; c.aluop = 3'b011; c.pcwc = 1'b1; c.pcsrc = 2'b01;
            c.bne = (op == 6'h05);
            cyc(rbit(), op, c);
        end else if (op == 6'h02) begin
            c = '0; c.pcw = 1'b1; c.pcsrc = 2'b10;
            cyc(rbit(), op, c);
        end else if (sel) begin
            c = '0; c.ill = 1'b1;
            for (int i = 0; i < 6; i++) cyc(rbit(), 6'($urandom), c);
        end else begin
            pend = 1'b1;
        end
        if (is_legal(op)) ret++;
    endtask

    logic [5:0] legal_ops [10] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
    logic [5:0] bad_ops   [6]  = '{6'h01, 6'h03, 6'h3F, 6'h10, 6'h20, 6'h2A};

    initial begin
        ctl_t       c;
        logic [5:0] op;
        logic [3:0] s0;

        sel = 1'b0;
        rst_seq();
        run_instr(6'h00, 0, 0);
        run_instr(6'h23, 0, 2);
        run_instr(6'h05, 0, 0);
        run_instr(6'h04, 1, 0);
        run_instr(6'h0F, 0, 0);
        run_instr(6'h3F, 0, 0);
        run_instr(6'h2B, 2, 1);
        run_instr(6'h02, 0, 0);
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) op = bad_ops[$urandom_range(0, 5)];
            else                           op = legal_ops[$urandom_range(0, 9)];
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        rst_seq();
        for (int n = 0; n < 17; n++) run_instr(6'h00, 0, 0);
        cyc(1'b1, 6'($urandom), v_fetch(1'b1, 1'b0));
        c = '0; c.srcb = 2'b11; c.aluop = 3'b100;
        cyc(1'b1, 6'h2B, c);
        c = '0; c.srca = 1'b1; c.srcb = 2'b10; c.aluop = 3'b010;
        cyc(1'b1, 6'h2B, c);
        c = '0; c.mwr = 1'b1; c.iord = 1'b1;
        cyc(1'b0, 6'h2B, c);
        @(negedge clk);
        #1;
        rst_a = 1'b1;
        #1;
        chk("reset_memwrite", {31'b0, a_mwr}, 32'd0);
        chk("reset_ctl", 32'(a_ctl), 32'd0);
        chk("reset_retired", {28'b0, a_ret}, 32'd0);
        chk("reset_state", {28'b0, a_state}, {28'b0, rst_enc_a});

        sel = 1'b1;
        rst_seq();
        run_instr(6'h00, 0, 0);
        run_instr(6'h02, 1, 0);
        run_instr(6'h0D, 0, 0);
        run_instr(6'h3F, 0, 0);
        @(negedge clk);
        #1;
        s0 = b_state;
        chk("trap_not_rst", {31'b0, (s0 != rst_enc_b)}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            mem_ready = rbit();
            @(negedge clk);
            #1;
            chk("trap_state", {28'b0, b_state}, {28'b0, s0});
            chk("trap_ill", {31'b0, b_ill}, 32'd1);
            chk("trap_retired", b_ret, ret);
        end

        repeat (3) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
